// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory pipe.
//   NOP            : word returned for erroring fetches and while no response is valid
//   OPC_J          : major opcode of the absolute jump used by the default image
//   imem_state_e   : fetch/load mode of the pipe
//   enc_j          : builds a jump to a word index
//   default_word   : contents of the boot image at a word index
package imem_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [5:0] OPC_J = 6'b00_0010;

  localparam int unsigned BOOT_ENTRY_WORD = 3;
  localparam int unsigned IRQ_ENTRY_WORD = 48;

  typedef enum logic [0:0] {
    StRun,
    StLoad
  } imem_state_e;

  function automatic logic [31:0] enc_j(input int unsigned target);
    return {OPC_J, 26'(target)};
  endfunction

  // Word 0 jumps past the vector table to the boot code, word 1 is the interrupt entry.
  function automatic logic [31:0] default_word(input int unsigned idx);
    case (idx)
      0: return enc_j(BOOT_ENTRY_WORD);
      1: return enc_j(IRQ_ENTRY_WORD);
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port synchronous RAM, DEPTH x 32, preloaded with the default boot image.
//   clk   : clock
//   en    : port enable
//   we    : write when high, read when low (with en)
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, holds until the next read
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Image is fixed at elaboration; no reset ever touches the array.
  logic [31:0] mem [DEPTH] = '{0: default_word(0), 1: default_word(1), default: NOP};
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instruction_memory_pipe.sv
// Instruction fetch memory with a one-cycle response pipe and an optional load mode.
// Optional feature: define IMEM_LOAD_EN to include the LOAD state and the ld_* port;
// without it the memory is read-only, ld_* are ignored and busy is tied low.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_addr/req_ready : fetch request handshake (byte address)
//   stall                      : hold the current response
//   flush                      : discard the in-flight response
//   resp_valid/resp_instr/resp_err : fetch response, err on misaligned or out-of-range
//   ld_start/ld_valid/ld_addr/ld_data/ld_done : load-mode control and write port
//   busy                       : high while in LOAD
module instruction_memory_pipe
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        stall,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_instr,
  output logic        resp_err,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_done,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  imem_state_e   state_q;
  logic          accept;
  logic          fetch_bad;
  logic          enter_load;
  logic          ld_write;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  // Boot address is a reference value for the surrounding core, not used here.
  logic [31:0] unused_reset_pc;
  assign unused_reset_pc = RESET_PC;

  assign req_ready = ~stall & (state_q == StRun);
  assign accept    = req_valid & req_ready;
  // Any address bit above the array index means out of range; never wrap.
  assign fetch_bad = (req_addr[1:0] != 2'b00) | (|req_addr[31:AW+2]);

`ifdef IMEM_LOAD_EN
  logic ld_bad;
  assign ld_bad     = (ld_addr[1:0] != 2'b00) | (|ld_addr[31:AW+2]);
  assign ld_write   = (state_q == StLoad) & ld_valid & ~ld_bad;
  assign enter_load = (state_q == StRun) & ld_start;
  assign ram_addr   = ld_write ? ld_addr[AW+1:2] : req_addr[AW+1:2];
  assign ram_wdata  = ld_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      unique case (state_q)
        StRun:  if (ld_start) state_q <= StLoad;
        StLoad: if (ld_done) state_q <= StRun;
        default: state_q <= StRun;
      endcase
    end
  end
`else
  logic unused_ld;
  assign unused_ld  = ^{ld_start, ld_valid, ld_addr, ld_data, ld_done};
  assign state_q    = StRun;
  assign ld_write   = 1'b0;
  assign enter_load = 1'b0;
  assign ram_addr   = req_addr[AW+1:2];
  assign ram_wdata  = 32'h0000_0000;
`endif

  assign busy = (state_q == StLoad);

  // Erroring fetches skip the array so its read register is left alone.
  assign ram_en = ld_write | (accept & ~fetch_bad);

  imem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (ld_write),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else if (flush || enter_load) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else if (!stall) begin
      resp_valid_q <= accept;
      resp_err_q   <= accept & fetch_bad;
    end
  end

  // Array read data is only shown for a valid, error-free response; otherwise NOP.
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_instr = (resp_valid_q && !resp_err_q) ? ram_rdata : NOP;

endmodule

// File: tb/tb_instruction_memory_pipe.sv
// Self-checking bench: directed cases with literal expectations, then random traffic
// checked every cycle against a behavioural model of the fetch/load rules.
module tb_instruction_memory_pipe;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW = 8;
`ifdef IMEM_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        req_ready;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic        resp_err;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic [31:0] ld_data = 32'h0;
  logic        ld_done = 1'b0;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  instruction_memory_pipe #(
    .DEPTH(DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .stall     (stall),
    .flush     (flush),
    .resp_valid(resp_valid),
    .resp_instr(resp_instr),
    .resp_err  (resp_err),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_done   (ld_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  logic        m_load = 1'b0;
  logic        e_valid = 1'b0;
  logic        e_err = 1'b0;
  logic [31:0] e_instr = 32'h0;

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 32'h0;
    m_mem[0] = 32'h0800_0003;
    m_mem[1] = 32'h0800_0030;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load  <= 1'b0;
      e_valid <= 1'b0;
      e_err   <= 1'b0;
      e_instr <= 32'h0;
    end else if (!m_load) begin
      if (flush || (LOAD_EN && ld_start)) begin
        e_valid <= 1'b0;
        e_err   <= 1'b0;
        e_instr <= 32'h0;
      end else if (!stall) begin
        if (req_valid) begin
          e_valid <= 1'b1;
          e_err   <= addr_bad(req_addr);
          e_instr <= addr_bad(req_addr) ? 32'h0 : m_mem[req_addr[AW+1:2]];
        end else begin
          e_valid <= 1'b0;
          e_err   <= 1'b0;
          e_instr <= 32'h0;
        end
      end
      if (LOAD_EN && ld_start) m_load <= 1'b1;
    end else begin
      e_valid <= 1'b0;
      e_err   <= 1'b0;
      e_instr <= 32'h0;
      if (ld_valid && !addr_bad(ld_addr)) m_mem[ld_addr[AW+1:2]] <= ld_data;
      if (ld_done) m_load <= 1'b0;
    end
  end

  // Inputs change 1 time unit after the rising edge, so the falling edge is stable.
  always @(negedge clk) begin
    chk("req_ready", {31'b0, req_ready}, {31'b0, !stall && !m_load});
    chk("busy", {31'b0, busy}, {31'b0, m_load});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, e_valid});
    if (e_valid || !rst_n) begin
      chk("resp_instr", resp_instr, e_instr);
      chk("resp_err", {31'b0, resp_err}, {31'b0, e_err});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_done = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    if (r < 5) a = 32'($urandom_range(0, 31)) * 4;
    else if (r < 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4;
    else if (r < 8) a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
    else a = (32'h1 << $urandom_range(AW + 2, 31)) | (32'($urandom_range(0, 31)) * 4);
    return a;
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_instr", resp_instr, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);

    // First cycle out of reset: ready, fetch word 0.
    rst_n = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h0;
    #1;
    chk("ready_after_rst", {31'b0, req_ready}, 32'h1);
    tick();
    chk("fetch0_valid", {31'b0, resp_valid}, 32'h1);
    chk("fetch0_instr", resp_instr, 32'h0800_0003);
    chk("fetch0_err", {31'b0, resp_err}, 32'h0);

    // Fetch 0x4, hold it with stall for 3 cycles, then fetch 0x8.
    req_addr = 32'h4;
    tick();
    chk("fetch4_instr", resp_instr, 32'h0800_0030);
    stall = 1'b1;
    req_addr = 32'h8;
    #1;
    chk("stall_ready", {31'b0, req_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_valid", {31'b0, resp_valid}, 32'h1);
      chk("stall_hold_instr", resp_instr, 32'h0800_0030);
    end
    stall = 1'b0;
    tick();
    chk("fetch8_valid", {31'b0, resp_valid}, 32'h1);
    chk("fetch8_instr", resp_instr, 32'h0);

    // Misaligned and out-of-range fetches.
    req_addr = 32'h6;
    tick();
    chk("misalign_err", {31'b0, resp_err}, 32'h1);
    chk("misalign_instr", resp_instr, 32'h0);
    req_addr = 32'h400;
    tick();
    chk("range_err", {31'b0, resp_err}, 32'h1);
    chk("range_instr", resp_instr, 32'h0);

    // Fetch dropped by flush in the same cycle.
    req_addr = 32'h0;
    flush = 1'b1;
    tick();
    chk("flush_valid", {31'b0, resp_valid}, 32'h0);
    idle();
    tick();
    chk("idle_valid", {31'b0, resp_valid}, 32'h0);

    if (LOAD_EN) begin
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      chk("load_busy", {31'b0, busy}, 32'h1);
      chk("load_ready", {31'b0, req_ready}, 32'h0);
      ld_valid = 1'b1;
      ld_addr = 32'h10;
      ld_data = 32'hDEAD_BEEF;
      tick();
      chk("load_busy2", {31'b0, busy}, 32'h1);
      ld_valid = 1'b0;
      ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
      chk("load_exit_busy", {31'b0, busy}, 32'h0);
      req_valid = 1'b1;
      req_addr = 32'h10;
      tick();
      req_valid = 1'b0;
      chk("loaded_instr", resp_instr, 32'hDEAD_BEEF);

      // Reset in the middle of LOAD keeps written words.
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      ld_valid = 1'b1;
      ld_addr = 32'h20;
      ld_data = 32'h1234_5678;
      tick();
      ld_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("midload_rst_busy", {31'b0, busy}, 32'h0);
      tick();
      rst_n = 1'b1;
      req_valid = 1'b1;
      req_addr = 32'h20;
      #1;
      chk("midload_rst_ready", {31'b0, req_ready}, 32'h1);
      tick();
      req_valid = 1'b0;
      chk("kept_instr", resp_instr, 32'h1234_5678);
    end

    // Random traffic; the compare process checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr = rand_addr();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      ld_start = ($urandom_range(0, 39) == 0);
      ld_valid = ($urandom_range(0, 1) == 0);
      ld_addr = rand_addr();
      ld_data = $urandom;
      ld_done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end

    idle();
    rst_n = 1'b1;
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_memory_pipe.md
INSTRUCTION_MEMORY_PIPE -- requirements
Module: instruction_memory_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words; power of two, 16..4096.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset, for bench/boot reference.
REQ-003 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request.
- req_addr  in  32  byte address of fetch.
- req_ready  out  1  fetch accepted this cycle when high with req_valid.
- stall  in  1  hold current response.
- flush  in  1  discard in-flight response.
- resp_valid  out  1  resp_instr valid.
- resp_instr  out  32  fetched word.
- resp_err  out  1  misaligned or out-of-range fetch.
- ld_start  in  1  enter load mode (IMEM_LOAD_EN only).
- ld_valid  in  1  load word present.
- ld_addr  in  32  byte address of load word.
- ld_data  in  32  load word.
- ld_done  in  1  leave load mode.
- busy  out  1  high while in LOAD.

Function
REQ-004 SHALL perform synchronous read: request accepted in cycle N gives resp_valid=1 in cycle N+1.
REQ-005 SHALL drive req_ready = ~stall & (state==RUN).
REQ-006 SHALL keep resp_valid, resp_instr and resp_err unchanged while stall=1.
REQ-007 SHALL, when no request is accepted and stall=0, drive resp_valid=0 next cycle.
REQ-008 SHALL index memory with req_addr[log2(DEPTH)+1:2].
REQ-009 SHALL, on req_addr[1:0]!=0, respond with resp_err=1 and resp_instr=32'h0000_0000 (NOP).
REQ-010 SHALL, when any req_addr bit above log2(DEPTH)+1 is set, respond with resp_err=1 and NOP; no silent wrap-around.
REQ-011 SHALL, on flush=1, clear resp_valid next cycle; flush overrides stall; a request accepted in the flush cycle SHALL be dropped.
REQ-012 SHALL implement states RUN and LOAD: RUN->LOAD on ld_start; LOAD->RUN on ld_done; ld_start in LOAD ignored.
REQ-013 SHALL, in LOAD with ld_valid=1, write ld_data at the ld_addr word index; misaligned or out-of-range load writes are dropped.
REQ-014 SHALL, on ld_valid and ld_done in the same cycle, perform the write and then return to RUN.
REQ-015 SHALL clear resp_valid on entry to LOAD; req_ready=0 and busy=1 throughout LOAD.
REQ-016 SHALL return, on a fetch in the first RUN cycle after LOAD, the newly loaded contents.
REQ-017 SHALL initialise memory at elaboration from the package default image: word 0 = jump to word 3, word 1 = jump to word 48 (interrupt entry), all others 0.

Reset
REQ-018 SHALL, while rst_n=0, force state=RUN, resp_valid=0, resp_instr=0, resp_err=0, busy=0.
REQ-019 SHALL leave memory contents unaltered by reset, including reset during LOAD; words written before reset are kept.
REQ-020 SHALL have req_ready=1 in the first cycle after rst_n deasserts, unless stall=1.

Configuration
REQ-021 SHALL, with macro IMEM_LOAD_EN defined, include the LOAD state and load port.
REQ-022 SHALL, with IMEM_LOAD_EN undefined, be read-only: ld_* ignored, busy tied 0, state fixed at RUN, memory holds only the default image.

Structure
REQ-023 SHALL take from shared package imem_pkg: the NOP constant, the opcode constants for J, the default-image function, and the state enum type.
REQ-024 SHALL contain one sub-module, imem_array: a parametrised single-port synchronous RAM with one read/write port, DEPTH x 32.

Verification
REQ-025 Reset then fetch 0x0 -> next cycle resp_valid=1, resp_instr=32'h0800_0003, resp_err=0.
REQ-026 Fetch 0x4, stall=1 for 3 cycles, then fetch 0x8 -> resp_instr=32'h0800_0030 held 3 cycles, then 0; req_ready=0 while stalled.
REQ-027 Fetch 0x6, then fetch 0x400 with DEPTH=256 -> resp_err=1 and resp_instr=0 both cycles.
REQ-028 With IMEM_LOAD_EN: ld_start, write 32'hDEAD_BEEF at 0x10, ld_done, fetch 0x10 -> busy=1 during load, then resp_instr=32'hDEAD_BEEF.
REQ-029 Fetch 0x0 with flush=1 in the same cycle -> resp_valid=0 next cycle.
REQ-030 Load 32'h1234_5678 at 0x20, pulse rst_n low mid-LOAD, fetch 0x20 -> state=RUN after reset, resp_instr=32'h1234_5678.
